// File: rtl/ram_reader_if.sv
// Buses of ram_reader: the RAM read port and the outgoing 16-bit sample stream.
// master = the reader, slave = the RAM / consumer side.
interface ram_reader_if #(
   parameter int ADDR_W = 14
);
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_rd_addr;
   logic [63:0]       i_rd_data;
   logic [15:0]       o_sample;
   logic              o_valid;
   logic              i_ready;

   modport master (
      output o_rd_en, o_rd_addr, o_sample, o_valid,
      input  i_rd_data, i_ready
   );

   modport slave (
      input  o_rd_en, o_rd_addr, o_sample, o_valid,
      output i_rd_data, i_ready
   );
endinterface

// File: rtl/ram_reader.sv
// Read-side companion of the sample RAM writer: fetches committed 64-bit words and streams them as
// four 16-bit samples. Optional counting-pattern checker enabled by macro RAMREADER_SEQCHECK_EN.
module ram_reader #(
   parameter int                ADDR_W     = 14,
   parameter int                RD_LATENCY = 2,
   parameter logic [ADDR_W-1:0] ADDR_FIRST = 14'h0001,
   parameter logic [ADDR_W-1:0] ADDR_LAST  = 14'h3FFF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_enable,
   input  logic          i_wr_en,
   ram_reader_if.master  bus,
   output logic [ADDR_W:0] o_level,
   output logic          o_overrun,
   output logic          o_seq_err
);

   localparam logic [ADDR_W:0] LVL_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] LVL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] LVL_CAP   = ({1'b0, ADDR_LAST} - {1'b0, ADDR_FIRST}) + LVL_ONE;
   localparam logic [2:0]      WAIT_LAST = 3'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UNPACK = 2'd3
   } state_t;

   function automatic logic [15:0] f_lane(input logic [63:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    f_lane = word[15:0];
         2'd1:    f_lane = word[31:16];
         2'd2:    f_lane = word[47:32];
         2'd3:    f_lane = word[63:48];
         default: f_lane = 16'h0000;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] f_ptr_next(input logic [ADDR_W-1:0] ptr);
      if (ptr == ADDR_LAST) begin
         f_ptr_next = ADDR_FIRST;
      end else begin
         f_ptr_next = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W:0]   r_level;
   logic              r_overrun;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_en;
   logic              r_valid;
   logic [15:0]       r_sample;
   logic [63:0]       r_hold;
   logic [1:0]        r_lane;
   logic [2:0]        r_wait_cnt;

   logic              w_has_work;
   logic              w_hs;
   logic              w_wait_done;
   logic              w_last_lane;
   logic              w_issue;
   logic              w_capture;
   logic              w_rd_en_nxt;
   logic              w_valid_nxt;
   logic [15:0]       w_sample_nxt;

   assign w_has_work  = i_enable && (r_level != LVL_ZERO);
   assign w_hs        = r_valid && bus.i_ready;
   assign w_wait_done = (r_wait_cnt == WAIT_LAST);
   assign w_last_lane = (r_lane == 2'd3);

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_has_work) begin
               w_state_next = ST_ISSUE;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_wait_done) begin
               w_state_next = ST_UNPACK;
            end else begin
               w_state_next = ST_WAIT;
            end
         end
         ST_UNPACK: begin
            if (w_hs && w_last_lane) begin
               if (w_has_work) begin
                  w_state_next = ST_ISSUE;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_state_next = ST_UNPACK;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // FSM output decode: values the output registers take on the next edge
   always_comb begin
      w_issue      = (r_state == ST_ISSUE);
      w_capture    = (r_state == ST_WAIT) && w_wait_done;
      w_rd_en_nxt  = (w_state_next == ST_ISSUE);
      w_valid_nxt  = (w_state_next == ST_UNPACK);
      w_sample_nxt = r_sample;
      if (w_capture) begin
         w_sample_nxt = f_lane(bus.i_rd_data, 2'd0);
      end else if (w_hs && !w_last_lane) begin
         w_sample_nxt = f_lane(r_hold, r_lane + 2'd1);
      end else begin
         w_sample_nxt = r_sample;
      end
   end

   // Read strobe/address, word holding register and lane sequencing
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_en    <= 1'b0;
         r_rd_addr  <= ADDR_FIRST;
         r_ptr      <= ADDR_FIRST;
         r_valid    <= 1'b0;
         r_sample   <= 16'h0000;
         r_hold     <= 64'h0000_0000_0000_0000;
         r_lane     <= 2'd0;
         r_wait_cnt <= 3'd0;
      end else begin
         r_rd_en  <= w_rd_en_nxt;
         r_valid  <= w_valid_nxt;
         r_sample <= w_sample_nxt;
         // r_ptr only moves at the end of ISSUE, so it is stable when the next ISSUE is entered
         if (w_rd_en_nxt) begin
            r_rd_addr <= r_ptr;
         end else begin
            r_rd_addr <= r_rd_addr;
         end
         if (w_issue) begin
            r_ptr      <= f_ptr_next(r_ptr);
            r_wait_cnt <= 3'd0;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
         end else begin
            r_wait_cnt <= r_wait_cnt;
         end
         if (w_capture) begin
            r_hold <= bus.i_rd_data;
            r_lane <= 2'd0;
         end else if (w_hs) begin
            r_lane <= r_lane + 2'd1;
         end else begin
            r_lane <= r_lane;
         end
      end
   end

   // Committed-but-unfetched word count with saturation and sticky overrun
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_level   <= LVL_ZERO;
         r_overrun <= 1'b0;
      end else begin
         case ({i_wr_en, w_issue})
            2'b10: begin
               if (r_level == LVL_CAP) begin
                  r_overrun <= 1'b1;
               end else begin
                  r_level <= r_level + LVL_ONE;
               end
            end
            2'b01: begin
               r_level <= r_level - LVL_ONE;
            end
            default: begin
               r_level <= r_level;
            end
         endcase
      end
   end

`ifdef RAMREADER_SEQCHECK_EN
   logic [15:0] r_prev;
   logic        r_have_prev;
   logic        r_seq_err;

   // Each accepted sample must be the previous accepted sample plus one (16-bit wrap)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev      <= 16'h0000;
         r_have_prev <= 1'b0;
         r_seq_err   <= 1'b0;
      end else if (w_hs) begin
         r_prev      <= r_sample;
         r_have_prev <= 1'b1;
         if (r_have_prev && (r_sample != (r_prev + 16'h0001))) begin
            r_seq_err <= 1'b1;
         end else begin
            r_seq_err <= r_seq_err;
         end
      end else begin
         r_prev      <= r_prev;
         r_have_prev <= r_have_prev;
         r_seq_err   <= r_seq_err;
      end
   end

   assign o_seq_err = r_seq_err;
`else
   assign o_seq_err = 1'b0;
`endif

   assign bus.o_rd_en   = r_rd_en;
   assign bus.o_rd_addr = r_rd_addr;
   assign bus.o_valid   = r_valid;
   assign bus.o_sample  = r_sample;
   assign o_level       = r_level;
   assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader: a synchronous RAM model with 2-cycle read latency,
// randomized writer/consumer stimulus and a queue-based reference of expected addresses and samples.
module tb_ram_reader;

   localparam logic [13:0] TB_FIRST = 14'h0001;
   localparam logic [13:0] TB_LAST  = 14'h001F;
   localparam int          CAP      = 31;
`ifdef RAMREADER_SEQCHECK_EN
   localparam bit          SEQ_ON   = 1'b1;
`else
   localparam bit          SEQ_ON   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        wr_en;
   logic [14:0] level;
   logic        overrun;
   logic        seq_err;

   int n_cmp = 0;
   int n_bad = 0;

   ram_reader_if #(.ADDR_W(14)) bus ();

   ram_reader #(
      .ADDR_W    (14),
      .RD_LATENCY(2),
      .ADDR_FIRST(TB_FIRST),
      .ADDR_LAST (TB_LAST)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_enable (enable),
      .i_wr_en  (wr_en),
      .bus      (bus),
      .o_level  (level),
      .o_overrun(overrun),
      .o_seq_err(seq_err)
   );

   always #5 clk = ~clk;

   // RAM model: address registered on the first edge, data presented after the second
   logic [63:0] mem [0:16383];
   logic        ram_v;
   logic [13:0] ram_a;
   always @(posedge clk) begin
      ram_v <= bus.o_rd_en;
      ram_a <= bus.o_rd_addr;
      if (ram_v) bus.i_rd_data <= mem[ram_a];
      else       bus.i_rd_data <= {$urandom, $urandom};
   end

   // Observation of issued reads and accepted samples
   logic [15:0] got_s[$];
   logic [13:0] got_a[$];
   logic [14:0] got_l[$];
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (bus.o_rd_en === 1'b1) begin
            got_a.push_back(bus.o_rd_addr);
            got_l.push_back(level);
         end
         if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) got_s.push_back(bus.o_sample);
      end
   end

   // Reference: every committed word is read at the writer's address, lanes in order
   logic [15:0] exp_s[$];
   logic [13:0] exp_a[$];
   logic [13:0] m_wptr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; enable = 1'b0; bus.i_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      got_s.delete(); got_a.delete(); got_l.delete();
      exp_s.delete(); exp_a.delete();
      m_wptr = TB_FIRST;
   endtask

   task automatic commit(input logic [63:0] w);
      mem[m_wptr] = w;
      exp_a.push_back(m_wptr);
      for (int i = 0; i < 4; i++) exp_s.push_back(w[16*i +: 16]);
      m_wptr = (m_wptr == TB_LAST) ? TB_FIRST : m_wptr + 14'd1;
      wr_en = 1'b1;
   endtask

   task automatic wait_samples(input int n, input int budget, output bit ok);
      int c;
      c = 0;
      while (got_s.size() < n && c < budget) begin tick(); c++; end
      ok = (got_s.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b1; enable = 1'b1; bus.i_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (bus.o_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %0b want 0", bus.o_rd_en); end
      n_cmp++; if (bus.o_rd_addr !== 14'h0001) begin n_bad++; $display("FAIL reset_rd_addr: got %0h want 1", bus.o_rd_addr); end
      n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.o_valid); end
      n_cmp++; if (bus.o_sample !== 16'h0000) begin n_bad++; $display("FAIL reset_sample: got %0h want 0", bus.o_sample); end
      n_cmp++; if (level !== 15'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
      n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq_err: got %0b want 0", seq_err); end
      do_reset();
   endtask

   task automatic test_single();
      logic        r_en [10];
      logic [13:0] r_a  [10];
      logic        r_v  [10];
      logic [15:0] r_s  [10];
      logic [14:0] r_l  [10];
      do_reset();
      enable = 1'b1; bus.i_ready = 1'b1;
      tick();
      commit(64'h0003_0002_0001_0000);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         r_en[k] = bus.o_rd_en; r_a[k] = bus.o_rd_addr; r_v[k] = bus.o_valid;
         r_s[k] = bus.o_sample; r_l[k] = level;
         tick();
         wr_en = 1'b0;
      end
      for (int k = 0; k < 10; k++) begin
         n_cmp++; if (r_en[k] !== (k == 2)) begin n_bad++; $display("FAIL single_rd_en[%0d]: got %0b want %0b", k, r_en[k], (k == 2)); end
         n_cmp++; if (r_v[k] !== (k >= 5 && k <= 8)) begin n_bad++; $display("FAIL single_valid[%0d]: got %0b want %0b", k, r_v[k], (k >= 5 && k <= 8)); end
         if (k >= 5 && k <= 8) begin
            n_cmp++; if (r_s[k] !== 16'(k - 5)) begin n_bad++; $display("FAIL single_sample[%0d]: got %0h want %0h", k, r_s[k], k - 5); end
         end
      end
      n_cmp++; if (r_a[2] !== 14'h0001) begin n_bad++; $display("FAIL single_addr: got %0h want 1", r_a[2]); end
      n_cmp++; if (r_l[1] !== 15'd1) begin n_bad++; $display("FAIL single_level_up: got %0d want 1", r_l[1]); end
      n_cmp++; if (r_l[3] !== 15'd0) begin n_bad++; $display("FAIL single_level_down: got %0d want 0", r_l[3]); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      bus.i_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin commit({$urandom, $urandom}); tick(); end
      wr_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (level !== 15'd3) begin n_bad++; $display("FAIL b2b_peak: got %0d want 3", level); end
      tick();
      enable = 1'b1;
      wait_samples(12, 200, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got %0d samples want 12", got_s.size()); end
      n_cmp++; if (got_a.size() != 3) begin n_bad++; $display("FAIL b2b_issues: got %0d want 3", got_a.size()); end
      for (int i = 0; i < 3 && i < got_a.size(); i++) begin
         n_cmp++; if (got_a[i] !== 14'(i + 1)) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %0h want %0h", i, got_a[i], i + 1); end
         n_cmp++; if (got_l[i] !== 15'(3 - i)) begin n_bad++; $display("FAIL b2b_level[%0d]: got %0d want %0d", i, got_l[i], 3 - i); end
      end
      for (int i = 0; i < 12 && i < got_s.size(); i++) begin
         n_cmp++; if (got_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL b2b_sample[%0d]: got %0h want %0h", i, got_s[i], exp_s[i]); end
      end
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (level !== 15'd0) begin n_bad++; $display("FAIL b2b_level_end: got %0d want 0", level); end
   endtask

   task automatic test_stall();
      logic [63:0] w;
      int          hs;
      int          c;
      do_reset();
      enable = 1'b1; bus.i_ready = 1'b1;
      tick();
      w = {$urandom, $urandom};
      commit(w);
      tick();
      wr_en = 1'b0;
      hs = 0; c = 0;
      do begin
         @(negedge clk);
         if (bus.o_valid && bus.i_ready) hs++;
         tick();
         c++;
      end while (hs < 2 && c < 50);
      n_cmp++; if (hs < 2) begin n_bad++; $display("FAIL stall_timeout: got %0d handshakes want 2", hs); end
      bus.i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, bus.o_valid); end
         n_cmp++; if (bus.o_sample !== w[47:32]) begin n_bad++; $display("FAIL stall_sample[%0d]: got %0h want %0h", i, bus.o_sample, w[47:32]); end
         tick();
      end
      bus.i_ready = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_lane3_valid: got %0b want 1", bus.o_valid); end
      n_cmp++; if (bus.o_sample !== w[63:48]) begin n_bad++; $display("FAIL stall_lane3: got %0h want %0h", bus.o_sample, w[63:48]); end
   endtask

   task automatic test_wrap_random();
      int nw;
      bit ok;
      localparam int NW = CAP + 6;
      do_reset();
      nw = 0;
      for (int cyc = 0; cyc < 4000 && nw < NW; cyc++) begin
         bus.i_ready = ($urandom_range(0, 3) != 0);
         enable      = ($urandom_range(0, 7) != 0);
         wr_en       = 1'b0;
         if ($urandom_range(0, 3) == 0 && (nw - got_a.size()) < CAP - 2) begin
            commit({$urandom, $urandom});
            nw++;
         end
         tick();
      end
      wr_en = 1'b0; enable = 1'b1; bus.i_ready = 1'b1;
      n_cmp++; if (nw != NW) begin n_bad++; $display("FAIL wrap_writes: got %0d want %0d", nw, NW); end
      wait_samples(4 * nw, 1000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got %0d samples want %0d", got_s.size(), 4 * nw); end
      n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL wrap_issues: got %0d want %0d", got_a.size(), exp_a.size()); end
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
         n_cmp++; if (got_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, got_a[i], exp_a[i]); end
      end
      for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
         n_cmp++; if (got_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL wrap_sample[%0d]: got %0h want %0h", i, got_s[i], exp_s[i]); end
      end
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (level !== 15'd0) begin n_bad++; $display("FAIL wrap_level_end: got %0d want 0", level); end
   endtask

   task automatic test_overrun();
      int c;
      do_reset();
      bus.i_ready = 1'b1;
      tick();
      wr_en = 1'b1;
      for (int i = 0; i < CAP; i++) tick();
      wr_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (level !== 15'(CAP)) begin n_bad++; $display("FAIL ovr_full_level: got %0d want %0d", level, CAP); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_full_flag: got %0b want 0", overrun); end
      tick();
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (level !== 15'(CAP)) begin n_bad++; $display("FAIL ovr_sat_level: got %0d want %0d", level, CAP); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sat_flag: got %0b want 1", overrun); end
      tick();
      enable = 1'b1;
      c = 0;
      while (got_a.size() < CAP && c < CAP * 10) begin tick(); c++; end
      for (int i = 0; i < 8; i++) tick();
      @(negedge clk);
      n_cmp++; if (got_a.size() != CAP) begin n_bad++; $display("FAIL ovr_drain_issues: got %0d want %0d", got_a.size(), CAP); end
      n_cmp++; if (level !== 15'd0) begin n_bad++; $display("FAIL ovr_drain_level: got %0d want 0", level); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_cleared: got %0b want 0", overrun); end
   endtask

   task automatic test_midop_reset();
      int c;
      bit seen;
      do_reset();
      enable = 1'b1; bus.i_ready = 1'b1;
      tick();
      commit({$urandom, $urandom}); tick();
      commit({$urandom, $urandom}); tick();
      wr_en = 1'b0;
      c = 0;
      do begin @(negedge clk); c++; end while (bus.o_rd_en !== 1'b1 && c < 20);
      n_cmp++; if (bus.o_rd_en !== 1'b1) begin n_bad++; $display("FAIL midrst_issue: got %0b want 1", bus.o_rd_en); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (level !== 15'd0) begin n_bad++; $display("FAIL midrst_level: got %0d want 0", level); end
      n_cmp++; if (bus.o_rd_en !== 1'b0 || bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: got rd_en=%0b valid=%0b want 0/0", bus.o_rd_en, bus.o_valid); end
      n_cmp++; if (bus.o_rd_addr !== 14'h0001) begin n_bad++; $display("FAIL midrst_addr: got %0h want 1", bus.o_rd_addr); end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         @(negedge clk);
         if (bus.o_valid === 1'b1 || bus.o_rd_en === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_discard: got activity=%0b want 0", seen); end
   endtask

   task automatic test_seqcheck();
      int   hs;
      int   c;
      bit   pending;
      logic err_at;
      logic err_after;
      logic early;
      bit   ok;
      do_reset();
      bus.i_ready = 1'b1;
      tick();
      commit(64'h0003_0002_0001_0000); tick();
      commit(64'h0007_0006_0005_0004); tick();
      commit(64'h000C_000B_000A_0009); tick();
      wr_en = 1'b0; enable = 1'b1;
      hs = 0; c = 0; pending = 1'b0; early = 1'b0; err_at = 1'bx; err_after = 1'bx;
      while (hs < 12 && c < 200) begin
         @(negedge clk);
         if (pending) begin err_after = seq_err; pending = 1'b0; end
         if (bus.o_valid && bus.i_ready) begin
            hs++;
            if (hs == 9) begin err_at = seq_err; pending = 1'b1; end
            if (hs < 9 && seq_err !== 1'b0) early = 1'b1;
         end
         tick();
         c++;
      end
      for (int i = 0; i < 4; i++) tick();
      @(negedge clk);
      n_cmp++; if (hs != 12) begin n_bad++; $display("FAIL seq_timeout: got %0d handshakes want 12", hs); end
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL seq_early: got %0b want 0", early); end
      n_cmp++; if (err_at !== 1'b0) begin n_bad++; $display("FAIL seq_before_bad: got %0b want 0", err_at); end
      n_cmp++; if (err_after !== SEQ_ON) begin n_bad++; $display("FAIL seq_rise: got %0b want %0b", err_after, SEQ_ON); end
      n_cmp++; if (seq_err !== SEQ_ON) begin n_bad++; $display("FAIL seq_sticky: got %0b want %0b", seq_err, SEQ_ON); end
      do_reset();
      enable = 1'b1; bus.i_ready = 1'b1;
      tick();
      commit(64'h0001_0000_FFFF_FFFE); tick();
      wr_en = 1'b0;
      wait_samples(4, 100, ok);
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_wrap_timeout: got %0d samples want 4", got_s.size()); end
      n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL seq_wrap_ok: got %0b want 0", seq_err); end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; enable = 1'b0; bus.i_ready = 1'b0; m_wptr = TB_FIRST;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_wrap_random();
      test_overrun();
      test_midop_reset();
      test_seqcheck();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_reader.md
Name: ram_reader

Overview:
- Read-side companion to the sample RAM writer. It tracks how many 64-bit words the writer has committed and fetches each one from the RAM read port.
- Each word is unpacked into four 16-bit samples and presented on a valid/ready stream.
- Sits between the dual-port sample RAM and the downstream sample consumer (packetiser/UART).

Parameters:
- ADDR_W, 14, RAM address width.
- RD_LATENCY, 2, cycles from o_rd_en to valid i_rd_data (1..7).
- ADDR_FIRST, 14'h0001, first and wrap-target address. Address 0 is never used.
- ADDR_LAST, 14'h3FFF, last address before wrap.

Ports:
- i_clk  in  1  system clock, all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  allows new RAM fetches. A fetch already in flight always completes.
- i_wr_en  in  1  writer commit strobe. One word committed per high cycle.
- o_rd_en  out  1  RAM read strobe, one-cycle pulse.
- o_rd_addr  out  14  RAM read address.
- i_rd_data  in  64  RAM read data. Lane0=[15:0], lane1=[31:16], lane2=[47:32], lane3=[63:48].
- o_sample  out  16  current sample.
- o_valid  out  1  o_sample valid.
- i_ready  in  1  consumer accepts when o_valid&&i_ready.
- o_level  out  15  words committed but not yet fetched.
- o_overrun  out  1  sticky: writer lapped the reader.
- o_seq_err  out  1  sticky sequence-check error (see Optional Feature).

Behaviour:
- Reset values:
  - o_rd_en=0, o_rd_addr=14'h0001, o_valid=0, o_sample=0.
  - o_level=0, o_overrun=0, o_seq_err=0.
  - State=IDLE, read pointer=ADDR_FIRST.
- Level counter (15 bit):
  - +1 on i_wr_en.
  - -1 on each fetch issue.
  - Both in the same cycle: unchanged.
  - Capacity = ADDR_LAST-ADDR_FIRST+1 = 16383.
  - i_wr_en while level==16383 and no issue that cycle: level holds, o_overrun set until reset.
- Read pointer:
  - Advances after each issue.
  - ADDR_LAST -> ADDR_FIRST wrap; 0x3FFF is followed by 0x0001.
  - o_rd_addr always equals the pointer of the current/last issue.
- State machine:
  - IDLE: if i_enable && level!=0 -> ISSUE.
  - ISSUE (1 cycle): o_rd_en=1, o_rd_addr=pointer, level decrements, pointer advances next cycle -> WAIT.
  - WAIT: count RD_LATENCY-1 cycles. On the cycle i_rd_data is valid (RD_LATENCY cycles after o_rd_en), capture it into the 64-bit holding register -> UNPACK, lane=0.
  - UNPACK:
    - o_valid=1, o_sample=holding lane[lane].
    - On handshake, lane increments.
    - Handshake on lane3: if i_enable && level!=0 -> ISSUE, else -> IDLE. o_valid drops for at least the ISSUE+WAIT cycles.
    - i_ready low: o_sample and o_valid stay stable (no change while stalled).
- Latency: i_wr_en at cycle T with level 0 and reader idle -> o_rd_en at T+2, first o_valid at T+2+RD_LATENCY+1.
- i_enable deassert mid-word: remaining lanes still delivered, then IDLE.
- i_rst mid-operation: everything returns to reset values the next cycle. The in-flight RAM read is discarded.

Optional Feature:
- Macro: RAMREADER_SEQCHECK_EN.
- Defined:
  - Checks the writer's counting pattern. Every accepted sample must equal the previous accepted sample+1 (16-bit wrap 0xFFFF->0x0000).
  - The first sample after reset is unchecked.
  - Any mismatch sets o_seq_err, sticky until reset.
- Undefined: o_seq_err tied 0 and no checker logic is present.

Test Plan:
1. Reset, then one i_wr_en pulse, RAM returns 64'h0003_0002_0001_0000, i_ready=1 -> o_rd_addr=0x0001. Samples 0,1,2,3 on four consecutive cycles. o_level returns to 0.
2. Three i_wr_en pulses back-to-back, i_ready=1 -> reads at addresses 1,2,3 in order. o_level peaks at 3 and steps down per issue.
3. i_ready held low for 5 cycles on lane2 -> o_sample stays at lane2 value with o_valid=1. Lane3 follows on the first cycle after ready returns.
4. Preload pointer near wrap via 16382 writes and reads -> read after address 0x3FFF issues at 0x0001. Address 0 never appears.
5. 16384 writes with i_enable=0 -> o_level saturates at 16383 and o_overrun=1. o_overrun stays high after draining until i_rst.
6. With RAMREADER_SEQCHECK_EN: feed 0..7, then a word with lane0=9 instead of 8 -> o_seq_err rises on that handshake. Without the macro, o_seq_err stays 0.
